// File: rtl/user_mgr_obi_arb_pkg.sv
// Shared definitions for the user-domain manager arbiter.
//   - default OBI config and the OBI request/response struct types
//   - requester enumeration and outstanding-transaction depth
//   - arbiter FSM state encoding
package user_mgr_obi_arb_pkg;

    localparam int unsigned ObiAddrWidth = 32;
    localparam int unsigned ObiDataWidth = 32;
    localparam int unsigned ObiIdWidth   = 1;

    typedef struct packed {
        int unsigned addr_width;
        int unsigned data_width;
        int unsigned id_width;
    } obi_cfg_t;

    localparam obi_cfg_t SbrObiCfg = '{
        addr_width: ObiAddrWidth,
        data_width: ObiDataWidth,
        id_width:   ObiIdWidth
    };

    typedef struct packed {
        logic [ObiAddrWidth-1:0]   addr;
        logic                      we;
        logic [ObiDataWidth/8-1:0] be;
        logic [ObiDataWidth-1:0]   wdata;
        logic [ObiIdWidth-1:0]     aid;
    } sbr_obi_a_chan_t;

    typedef struct packed {
        sbr_obi_a_chan_t a;
        logic            req;
    } sbr_obi_req_t;

    typedef struct packed {
        logic [ObiDataWidth-1:0] rdata;
        logic [ObiIdWidth-1:0]   rid;
        logic                    err;
    } sbr_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        sbr_obi_r_chan_t r;
    } sbr_obi_rsp_t;

    // User-domain requesters sharing the manager port.
    localparam int unsigned NumUserMgrs = 2;

    typedef enum logic [0:0] {
        UserDma    = 1'b0,
        UserPulser = 1'b1
    } user_mgr_e;

    localparam int unsigned UserMgrMaxTrans = 2;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/user_mgr_arb_idx_fifo.sv
// Index FIFO holding the requester index of every outstanding transaction,
// oldest at the head, so responses can be routed back in order.
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   push_i, data_i  enqueue an index
//   pop_i           dequeue the head (ignored when empty)
//   data_o          head entry
//   full_o, empty_o, count_o  fill status
module user_mgr_arb_idx_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push while full is accepted only alongside a pop: the head is read
    // out before the slot is overwritten at the clock edge.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/user_mgr_obi_arb.sv
// Round-robin arbiter sharing the user-domain OBI manager port between
// NumSbrPorts requesters. The address phase of a requester that was not
// granted immediately is locked until the grant; at most NumMaxTrans
// transactions are outstanding; responses are routed back in order.
// Ports:
//   clk_i, rst_ni     clock, synchronous active-low reset
//   sbr_ports_req_i   requester requests
//   sbr_ports_rsp_o   requester responses (r broadcast, gnt/rvalid per port)
//   mgr_port_req_o    shared manager request
//   mgr_port_rsp_i    shared manager response
//   busy_o            transaction outstanding or address phase locked
//   rsp_unexp_o       sticky: rvalid seen with nothing outstanding
// Build option: define USER_MGR_OBI_ARB_ERR_EN to implement rsp_unexp_o;
// otherwise it is tied low.
module user_mgr_obi_arb
    import user_mgr_obi_arb_pkg::*;
#(
    parameter int unsigned NumSbrPorts = NumUserMgrs,
    parameter int unsigned NumMaxTrans = UserMgrMaxTrans,
    parameter obi_cfg_t    ObiCfg      = SbrObiCfg,
    parameter type         obi_req_t   = sbr_obi_req_t,
    parameter type         obi_rsp_t   = sbr_obi_rsp_t
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  obi_req_t [NumSbrPorts-1:0] sbr_ports_req_i,
    output obi_rsp_t [NumSbrPorts-1:0] sbr_ports_rsp_o,
    output obi_req_t                   mgr_port_req_o,
    input  obi_rsp_t                   mgr_port_rsp_i,
    output logic                       busy_o,
    output logic                       rsp_unexp_o
);

    localparam int unsigned IdxW = (NumSbrPorts > 1) ? $clog2(NumSbrPorts) : 1;
    localparam int unsigned CntW = $clog2(NumMaxTrans + 1);

    arb_state_e             state_q, state_d;
    logic [IdxW-1:0]        lock_idx_q, lock_idx_d;
    logic [IdxW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]        win_idx, cand;
    logic                   any_req;
    logic [NumSbrPorts-1:0] gnt_vec;
    logic                   push;
    logic [IdxW-1:0]        push_idx;
    logic                   fifo_full, fifo_empty;
    logic [IdxW-1:0]        fifo_head;
    logic [CntW-1:0]        fifo_count;
    logic                   rsp_fwd;

    function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] v);
        return (int'(v) == NumSbrPorts - 1) ? '0 : v + 1'b1;
    endfunction

    // First requesting port at or after rr_ptr, circularly.
    always_comb begin
        any_req = 1'b0;
        win_idx = rr_ptr_q;
        cand    = rr_ptr_q;
        for (int i = 0; i < NumSbrPorts; i++) begin
            if (!any_req && sbr_ports_req_i[cand].req) begin
                any_req = 1'b1;
                win_idx = cand;
            end
            cand = wrap_inc(cand);
        end
    end

    always_comb begin
        state_d        = state_q;
        lock_idx_d     = lock_idx_q;
        rr_ptr_d       = rr_ptr_q;
        mgr_port_req_o = '0;
        gnt_vec        = '0;
        push           = 1'b0;
        push_idx       = win_idx;
        if (rst_ni) begin
            case (state_q)
                ARB_IDLE: begin
                    // Full is only checked here; a lock is taken with a free slot
                    // and nothing can be pushed while locked.
                    if (any_req && !fifo_full) begin
                        mgr_port_req_o = sbr_ports_req_i[win_idx];
                        if (mgr_port_rsp_i.gnt) begin
                            push             = 1'b1;
                            gnt_vec[win_idx] = 1'b1;
                            rr_ptr_d         = wrap_inc(win_idx);
                        end else begin
                            state_d    = ARB_LOCKED;
                            lock_idx_d = win_idx;
                        end
                    end
                end
                ARB_LOCKED: begin
                    push_idx = lock_idx_q;
                    if (!sbr_ports_req_i[lock_idx_q].req) begin
                        // Requester withdrew mid address phase: drop the lock.
                        state_d = ARB_IDLE;
                    end else begin
                        mgr_port_req_o = sbr_ports_req_i[lock_idx_q];
                        if (mgr_port_rsp_i.gnt) begin
                            push                = 1'b1;
                            gnt_vec[lock_idx_q] = 1'b1;
                            rr_ptr_d            = wrap_inc(lock_idx_q);
                            state_d             = ARB_IDLE;
                        end
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ARB_IDLE;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    user_mgr_arb_idx_fifo #(
        .Depth (NumMaxTrans),
        .Width (IdxW)
    ) i_idx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (push_idx),
        .pop_i   (rsp_fwd),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // A response with nothing outstanding has no owner and is dropped.
    assign rsp_fwd = rst_ni && mgr_port_rsp_i.rvalid && !fifo_empty;

    always_comb begin
        sbr_ports_rsp_o = '0;
        for (int i = 0; i < NumSbrPorts; i++) begin
            sbr_ports_rsp_o[i].r      = mgr_port_rsp_i.r;
            sbr_ports_rsp_o[i].gnt    = gnt_vec[i];
            sbr_ports_rsp_o[i].rvalid = rsp_fwd && (int'(fifo_head) == i);
        end
    end

    assign busy_o = (fifo_count != '0) || (state_q == ARB_LOCKED);

`ifdef USER_MGR_OBI_ARB_ERR_EN
    logic rsp_unexp_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rsp_unexp_q <= 1'b0;
        end else if (mgr_port_rsp_i.rvalid && fifo_empty) begin
            rsp_unexp_q <= 1'b1;
        end
    end

    assign rsp_unexp_o = rsp_unexp_q;
`else
    assign rsp_unexp_o = 1'b0;
`endif

    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert ($bits(mgr_port_rsp_i.r.rdata) == ObiCfg.data_width)
                else $error("user_mgr_obi_arb: rdata width differs from ObiCfg");
            if (state_q == ARB_LOCKED) begin
                assert (sbr_ports_req_i[lock_idx_q].req)
                    else $error("user_mgr_obi_arb: locked requester dropped req before gnt");
            end
        end
    end

endmodule

// File: tb/tb_user_mgr_obi_arb.sv
module tb_user_mgr_obi_arb;
    import user_mgr_obi_arb_pkg::*;

    localparam int NP = 2;
    localparam logic [31:0] A0  = 32'h0000_0001;
    localparam logic [31:0] A1  = 32'h2000_0010;
    localparam logic [31:0] KEY = 32'hCAFE_0000;
`ifdef USER_MGR_OBI_ARB_ERR_EN
    localparam logic EXP_UNEXP = 1'b1;
`else
    localparam logic EXP_UNEXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sbr_obi_req_t [NP-1:0] sbr_req;
    sbr_obi_rsp_t [NP-1:0] sbr_rsp;
    sbr_obi_req_t          mgr_req;
    sbr_obi_rsp_t          mgr_rsp;
    logic                  busy, unexp;

    user_mgr_obi_arb #(
        .NumSbrPorts (NP),
        .NumMaxTrans (2),
        .ObiCfg      (SbrObiCfg),
        .obi_req_t   (sbr_obi_req_t),
        .obi_rsp_t   (sbr_obi_rsp_t)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .sbr_ports_req_i (sbr_req),
        .sbr_ports_rsp_o (sbr_rsp),
        .mgr_port_req_o  (mgr_req),
        .mgr_port_rsp_i  (mgr_rsp),
        .busy_o          (busy),
        .rsp_unexp_o     (unexp)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] port_addr [NP];

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q [$];   // what each requester should get back, in order
    logic [31:0] sub_q [$];   // what the subordinate model will return

    typedef struct {
        logic [1:0]  req;
        logic        gnt;
        logic        rv;
        logic        e_mreq;
        logic [31:0] e_addr;
        logic [1:0]  e_gnt;
        logic [1:0]  e_rv;
        logic        e_busy;
    } vec_t;

    vec_t tab [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] rq, input logic g, input logic rv,
                                input logic em, input logic [31:0] ea,
                                input logic [1:0] eg, input logic [1:0] er, input logic eb);
        vec_t v;
        v.req = rq; v.gnt = g; v.rv = rv;
        v.e_mreq = em; v.e_addr = ea; v.e_gnt = eg; v.e_rv = er; v.e_busy = eb;
        return v;
    endfunction

    task automatic drive(input logic [1:0] rq, input logic g, input logic rv);
        for (int p = 0; p < NP; p++) begin
            sbr_req[p]        = '0;
            sbr_req[p].req    = rq[p];
            sbr_req[p].a.addr = port_addr[p];
            sbr_req[p].a.be   = 4'hF;
        end
        mgr_rsp        = '0;
        mgr_rsp.gnt    = g;
        mgr_rsp.rvalid = rv;
        if (rv) mgr_rsp.r.rdata = (sub_q.size() != 0) ? sub_q.pop_front() : 32'hDEAD_BEEF;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: responses are compared as they appear; new transactions
    // are recorded on both sides of the arbiter.
    always @(negedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (sbr_rsp[p].rvalid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rsp_route: rvalid on port %0d, expected none", p);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_port", p, e.port);
                    chk("rsp_rdata", sbr_rsp[p].r.rdata, e.data);
                end
            end
        end
        if (mgr_req.req && mgr_rsp.gnt) sub_q.push_back(mgr_req.a.addr ^ KEY);
        for (int p = 0; p < NP; p++) begin
            if (sbr_rsp[p].gnt) exp_q.push_back('{port: p, data: port_addr[p] ^ KEY});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        port_addr[0] = A0;
        port_addr[1] = A1;
        rst_n = 1'b0;
        // Port 0 requests during reset: nothing may be forwarded or granted.
        drive(2'b01, 1'b1, 1'b0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_mreq", mgr_req.req, 1'b0);
        chk("rst_gnt", {sbr_rsp[1].gnt, sbr_rsp[0].gnt}, 2'b00);
        chk("rst_rvalid", {sbr_rsp[1].rvalid, sbr_rsp[0].rvalid}, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_unexp", unexp, 1'b0);
        next_cycle();
        drive(2'b00, 1'b0, 1'b0);
        rst_n = 1'b1;

        // req, gnt, rv | mgr req, mgr addr, sbr gnt, sbr rvalid, busy
        // single port 0, rvalid two cycles after grant
        tab.push_back(mk(2'b01, 1'b1, 1'b0, 1'b1, A0, 2'b01, 2'b00, 1'b0));
        tab.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, '0, 2'b00, 2'b00, 1'b1));
        tab.push_back(mk(2'b00, 1'b0, 1'b1, 1'b0, '0, 2'b00, 2'b01, 1'b1));
        tab.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, '0, 2'b00, 2'b00, 1'b0));
        // both request, always granted, responses one cycle behind
        tab.push_back(mk(2'b11, 1'b1, 1'b0, 1'b1, A1, 2'b10, 2'b00, 1'b0));
        tab.push_back(mk(2'b11, 1'b1, 1'b1, 1'b1, A0, 2'b01, 2'b10, 1'b1));
        tab.push_back(mk(2'b11, 1'b1, 1'b1, 1'b1, A1, 2'b10, 2'b01, 1'b1));
        tab.push_back(mk(2'b11, 1'b1, 1'b1, 1'b1, A0, 2'b01, 2'b10, 1'b1));
        tab.push_back(mk(2'b00, 1'b0, 1'b1, 1'b0, '0, 2'b00, 2'b01, 1'b1));
        tab.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, '0, 2'b00, 2'b00, 1'b0));
        // port 1 locked for three cycles while port 0 waits
        tab.push_back(mk(2'b10, 1'b0, 1'b0, 1'b1, A1, 2'b00, 2'b00, 1'b0));
        tab.push_back(mk(2'b11, 1'b0, 1'b0, 1'b1, A1, 2'b00, 2'b00, 1'b1));
        tab.push_back(mk(2'b11, 1'b0, 1'b0, 1'b1, A1, 2'b00, 2'b00, 1'b1));
        tab.push_back(mk(2'b11, 1'b1, 1'b0, 1'b1, A1, 2'b10, 2'b00, 1'b1));
        tab.push_back(mk(2'b01, 1'b1, 1'b0, 1'b1, A0, 2'b01, 2'b00, 1'b1));
        tab.push_back(mk(2'b00, 1'b0, 1'b1, 1'b0, '0, 2'b00, 2'b10, 1'b1));
        tab.push_back(mk(2'b00, 1'b0, 1'b1, 1'b0, '0, 2'b00, 2'b01, 1'b1));
        tab.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, '0, 2'b00, 2'b00, 1'b0));
        // outstanding limit of two, pop while full, push+pop at one
        tab.push_back(mk(2'b01, 1'b1, 1'b0, 1'b1, A0, 2'b01, 2'b00, 1'b0));
        tab.push_back(mk(2'b01, 1'b1, 1'b0, 1'b1, A0, 2'b01, 2'b00, 1'b1));
        tab.push_back(mk(2'b01, 1'b1, 1'b0, 1'b0, '0, 2'b00, 2'b00, 1'b1));
        tab.push_back(mk(2'b01, 1'b1, 1'b0, 1'b0, '0, 2'b00, 2'b00, 1'b1));
        tab.push_back(mk(2'b01, 1'b1, 1'b1, 1'b0, '0, 2'b00, 2'b01, 1'b1));
        tab.push_back(mk(2'b01, 1'b1, 1'b1, 1'b1, A0, 2'b01, 2'b01, 1'b1));
        tab.push_back(mk(2'b01, 1'b1, 1'b0, 1'b1, A0, 2'b01, 2'b00, 1'b1));
        tab.push_back(mk(2'b01, 1'b1, 1'b0, 1'b0, '0, 2'b00, 2'b00, 1'b1));
        tab.push_back(mk(2'b00, 1'b0, 1'b1, 1'b0, '0, 2'b00, 2'b01, 1'b1));
        tab.push_back(mk(2'b00, 1'b0, 1'b1, 1'b0, '0, 2'b00, 2'b01, 1'b1));
        tab.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, '0, 2'b00, 2'b00, 1'b0));

        foreach (tab[i]) begin
            drive(tab[i].req, tab[i].gnt, tab[i].rv);
            @(negedge clk);
            chk($sformatf("v%0d_mreq", i), mgr_req.req, tab[i].e_mreq);
            if (tab[i].e_mreq) chk($sformatf("v%0d_maddr", i), mgr_req.a.addr, tab[i].e_addr);
            chk($sformatf("v%0d_gnt", i), {sbr_rsp[1].gnt, sbr_rsp[0].gnt}, tab[i].e_gnt);
            chk($sformatf("v%0d_rvalid", i), {sbr_rsp[1].rvalid, sbr_rsp[0].rvalid}, tab[i].e_rv);
            chk($sformatf("v%0d_busy", i), busy, tab[i].e_busy);
            next_cycle();
        end
        chk("unexp_clean", unexp, 1'b0);

        // Reset with two transactions outstanding.
        drive(2'b01, 1'b1, 1'b0);
        next_cycle();
        drive(2'b01, 1'b1, 1'b0);
        next_cycle();
        drive(2'b00, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", busy, 1'b1);
        next_cycle();
        @(negedge clk);
        chk("mid_rst_busy", busy, 1'b0);
        exp_q.delete();
        sub_q.delete();
        next_cycle();
        rst_n = 1'b1;
        drive(2'b00, 1'b0, 1'b1);
        @(negedge clk);
        chk("drop_rvalid", {sbr_rsp[1].rvalid, sbr_rsp[0].rvalid}, 2'b00);
        chk("drop_busy", busy, 1'b0);
        next_cycle();
        drive(2'b00, 1'b0, 1'b0);
        @(negedge clk);
        chk("unexp_set", unexp, EXP_UNEXP);
        next_cycle();
        // Pointer restarts at 0 but only port 1 requests; flag stays as is.
        drive(2'b10, 1'b1, 1'b0);
        @(negedge clk);
        chk("post_rst_gnt", {sbr_rsp[1].gnt, sbr_rsp[0].gnt}, 2'b10);
        next_cycle();
        drive(2'b00, 1'b0, 1'b1);
        @(negedge clk);
        chk("post_rst_rvalid", {sbr_rsp[1].rvalid, sbr_rsp[0].rvalid}, 2'b10);
        chk("post_rst_rdata", sbr_rsp[1].r.rdata, 32'hEAFE_0010);
        next_cycle();
        drive(2'b00, 1'b0, 1'b0);
        @(negedge clk);
        chk("unexp_sticky", unexp, EXP_UNEXP);
        chk("end_busy", busy, 1'b0);
        chk("sb_drained", exp_q.size(), 0);
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
